// File: rtl/multicycle_control_unit.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the MIPS core, with memory-ack timeout, halt and retire counter.
// Optional DEBUG_STEP_EN macro adds the i_step port and halts after every retired instruction.
module multicycle_control_unit #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 4,
  parameter int CNT_W       = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_halt,
`ifdef DEBUG_STEP_EN
  input  logic             i_step,
`endif
  input  logic [5:0]       i_opcode,
  input  logic [5:0]       i_funct,
  input  logic             i_zero,
  input  logic             i_mem_ack,
  output logic             o_mem_rd_en,
  output logic             o_mem_wr_en,
  output logic             o_ir_wr_en,
  output logic             o_pc_wr_en,
  output logic [1:0]       o_pc_src,
  output logic             o_reg_wr_en,
  output logic [1:0]       o_wb_src,
  output logic [1:0]       o_reg_dst,
  output logic [3:0]       o_alu_opcode,
  output logic             o_alu_src_b,
  output logic [2:0]       o_state,
  output logic             o_busy,
  output logic             o_instr_done,
  output logic [CNT_W-1:0] o_instr_count,
  output logic             o_timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_ERROR  = 3'd7
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  state_t          state, state_next;
  logic [5:0]      op_reg, funct_reg;
  logic [TO_W-1:0] to_cnt;
  logic [CNT_W-1:0] count;

  logic go, step_mode, timeout, retire;
  logic is_rtype, is_jr, is_jalr, is_imm, is_lw, is_sw, is_beq, is_bne, is_j, is_jal;
  logic [3:0] alu_dec;
  logic       srcb_dec;

`ifdef DEBUG_STEP_EN
  assign go        = i_start | i_step;
  assign step_mode = 1'b1;
`else
  assign go        = i_start;
  assign step_mode = 1'b0;
`endif

  assign timeout  = (to_cnt == TO_LAST);
  assign is_rtype = (op_reg == 6'b000000);
  assign is_jr    = is_rtype && (funct_reg == 6'b001000);
  assign is_jalr  = is_rtype && (funct_reg == 6'b001001);
  assign is_imm   = (op_reg[5:3] == 3'b001);
  assign is_lw    = (op_reg == 6'b100011);
  assign is_sw    = (op_reg == 6'b101011);
  assign is_beq   = (op_reg == 6'b000100);
  assign is_bne   = (op_reg == 6'b000101);
  assign is_j     = (op_reg == 6'b000010);
  assign is_jal   = (op_reg == 6'b000011);

  // ALU control from the fields latched in DECODE
  always_comb begin
    alu_dec  = 4'b0000;
    srcb_dec = 1'b0;
    if (is_rtype) begin
      case (funct_reg)
        6'b000000: begin alu_dec = 4'b0001; srcb_dec = 1'b1; end
        6'b000010: begin alu_dec = 4'b0000; srcb_dec = 1'b1; end
        6'b000011: begin alu_dec = 4'b0010; srcb_dec = 1'b1; end
        6'b000100: alu_dec = 4'b0001;
        6'b000110: alu_dec = 4'b0000;
        6'b000111: alu_dec = 4'b0010;
        6'b100001: alu_dec = 4'b0100;
        6'b100011: alu_dec = 4'b0101;
        6'b100100: alu_dec = 4'b0110;
        6'b100101: alu_dec = 4'b0111;
        6'b100110: alu_dec = 4'b1000;
        6'b100111: alu_dec = 4'b1001;
        6'b101010: alu_dec = 4'b1010;
        default:   alu_dec = 4'b0000;
      endcase
    end else if (is_imm) begin
      srcb_dec = 1'b1;
      case (op_reg[2:0])
        3'b000:  alu_dec = 4'b1100;
        3'b010:  alu_dec = 4'b1010;
        3'b100:  alu_dec = 4'b0110;
        3'b101:  alu_dec = 4'b0111;
        3'b110:  alu_dec = 4'b1000;
        3'b111:  alu_dec = 4'b0011;
        default: alu_dec = 4'b0000;
      endcase
    end else if (is_lw || is_sw) begin
      alu_dec  = 4'b0100;
      srcb_dec = 1'b1;
    end else if (is_beq || is_bne) begin
      alu_dec = 4'b1011;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_HALT: if (go) state_next = S_FETCH;
      S_FETCH: begin
        if (i_mem_ack)    state_next = S_DECODE;
        else if (timeout) state_next = S_ERROR;
      end
      S_DECODE: state_next = S_EXEC;
      S_EXEC: begin
        if (is_lw || is_sw)                                       state_next = S_MEM;
        else if (is_jal || (is_rtype && !is_jr) || is_imm)        state_next = S_WB;
        else                                                      state_next = (i_halt || step_mode) ? S_HALT : S_FETCH;
      end
      S_MEM: begin
        if (i_mem_ack)    state_next = is_lw ? S_WB : ((i_halt || step_mode) ? S_HALT : S_FETCH);
        else if (timeout) state_next = S_ERROR;
      end
      S_WB:    state_next = (i_halt || step_mode) ? S_HALT : S_FETCH;
      default: state_next = S_ERROR;
    endcase
  end

  assign retire = ((state == S_EXEC) || (state == S_MEM) || (state == S_WB)) &&
                  ((state_next == S_FETCH) || (state_next == S_HALT));

  always_comb begin
    o_mem_rd_en  = 1'b0;
    o_mem_wr_en  = 1'b0;
    o_ir_wr_en   = 1'b0;
    o_pc_wr_en   = 1'b0;
    o_pc_src     = 2'b00;
    o_reg_wr_en  = 1'b0;
    o_wb_src     = 2'b00;
    o_reg_dst    = 2'b00;
    o_alu_opcode = 4'b0000;
    o_alu_src_b  = 1'b0;
    case (state)
      S_FETCH: begin
        o_mem_rd_en = 1'b1;
        o_ir_wr_en  = i_mem_ack;
        o_pc_wr_en  = i_mem_ack;
      end
      S_EXEC: begin
        o_alu_opcode = alu_dec;
        o_alu_src_b  = srcb_dec;
        if (is_jr || is_jalr) begin
          o_pc_wr_en = 1'b1;
          o_pc_src   = 2'b11;
        end else if (is_j || is_jal) begin
          o_pc_wr_en = 1'b1;
          o_pc_src   = 2'b10;
        end else if (is_beq || is_bne) begin
          o_pc_wr_en = is_beq ? i_zero : !i_zero;
          o_pc_src   = 2'b01;
        end
      end
      S_MEM: begin
        o_mem_rd_en = is_lw;
        o_mem_wr_en = is_sw;
      end
      S_WB: begin
        o_reg_wr_en = 1'b1;
        if (is_jal) begin
          o_reg_dst = 2'b11;
          o_wb_src  = 2'b10;
        end else if (is_jalr) begin
          o_reg_dst = 2'b01;
          o_wb_src  = 2'b10;
        end else if (is_lw) begin
          o_wb_src  = 2'b01;
        end else if (is_rtype) begin
          o_reg_dst = 2'b01;
        end
      end
      default: ;
    endcase
  end

  // Timeout counter restarts on every state change, so entry to FETCH/MEM sees zero
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      op_reg    <= '0;
      funct_reg <= '0;
      to_cnt    <= '0;
      count     <= '0;
    end else begin
      if (state == S_DECODE) begin
        op_reg    <= i_opcode;
        funct_reg <= i_funct;
      end
      if (state_next != state)
        to_cnt <= '0;
      else if (((state == S_FETCH) || (state == S_MEM)) && !i_mem_ack)
        to_cnt <= to_cnt + 1'b1;
      if (retire)
        count <= count + 1'b1;
    end
  end

  assign o_state       = state;
  assign o_busy        = (state == S_FETCH) || (state == S_DECODE) || (state == S_EXEC) ||
                         (state == S_MEM) || (state == S_WB);
  assign o_instr_done  = retire;
  assign o_instr_count = count;
  assign o_timeout_err = (state == S_ERROR);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: per-cycle expected outputs queued as stimulus is driven.
module tb_multicycle_control_unit;

  logic        i_clk = 1'b0;
  logic        i_rst_n, i_start, i_halt, i_zero, i_mem_ack;
`ifdef DEBUG_STEP_EN
  logic        i_step;
`endif
  logic [5:0]  i_opcode, i_funct;
  logic        o_mem_rd_en, o_mem_wr_en, o_ir_wr_en, o_pc_wr_en, o_reg_wr_en, o_alu_src_b;
  logic [1:0]  o_pc_src, o_wb_src, o_reg_dst;
  logic [3:0]  o_alu_opcode;
  logic [2:0]  o_state;
  logic        o_busy, o_instr_done, o_timeout_err;
  logic [31:0] o_instr_count;

  multicycle_control_unit #(.MEM_TIMEOUT(15), .TO_W(4), .CNT_W(32)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_halt(i_halt),
`ifdef DEBUG_STEP_EN
    .i_step(i_step),
`endif
    .i_opcode(i_opcode), .i_funct(i_funct), .i_zero(i_zero), .i_mem_ack(i_mem_ack),
    .o_mem_rd_en(o_mem_rd_en), .o_mem_wr_en(o_mem_wr_en), .o_ir_wr_en(o_ir_wr_en),
    .o_pc_wr_en(o_pc_wr_en), .o_pc_src(o_pc_src), .o_reg_wr_en(o_reg_wr_en),
    .o_wb_src(o_wb_src), .o_reg_dst(o_reg_dst), .o_alu_opcode(o_alu_opcode),
    .o_alu_src_b(o_alu_src_b), .o_state(o_state), .o_busy(o_busy),
    .o_instr_done(o_instr_done), .o_instr_count(o_instr_count), .o_timeout_err(o_timeout_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [2:0]  st;
    logic        rd, wr, ir, pcw;
    logic [1:0]  pcs;
    logic        rw;
    logic [1:0]  wbs, dst;
    logic        srcb;
    logic [3:0]  alu;
    logic        busy, done, err;
    logic [31:0] cnt;
  } obs_t;

  obs_t        exp_q[$];
  string       tag_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_cnt = 0;

  // mem = {rd, wr, ir, pcw}; busy/err follow from the state number
  function automatic void push(string tag, int st, int mem, int pcs, int rw, int wbs, int dst,
                               int srcb, int alu, int done);
    obs_t e;
    e.st   = 3'(st);
    {e.rd, e.wr, e.ir, e.pcw} = 4'(mem);
    e.pcs  = 2'(pcs);
    e.rw   = 1'(rw);
    e.wbs  = 2'(wbs);
    e.dst  = 2'(dst);
    e.srcb = 1'(srcb);
    e.alu  = 4'(alu);
    e.busy = (st >= 1) && (st <= 5);
    e.done = 1'(done);
    e.err  = (st == 7);
    e.cnt  = exp_cnt;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    if (done != 0) exp_cnt = exp_cnt + 1;
  endfunction

  task automatic check_now();
    obs_t  got, e;
    string t;
    got = {o_state, o_mem_rd_en, o_mem_wr_en, o_ir_wr_en, o_pc_wr_en, o_pc_src, o_reg_wr_en,
           o_wb_src, o_reg_dst, o_alu_src_b, o_alu_opcode, o_busy, o_instr_done, o_timeout_err,
           o_instr_count};
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_underflow observed=%h expected=<none>", got);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (got === e) else begin
        miscompares++;
        $error("FAIL %s observed=%h expected=%h", t, got, e);
      end
      $display("vec %0d %s state=%0d obs=%h", vectors, t, o_state, got);
    end
  endtask

  task automatic step(input logic ack, input logic zero);
    i_mem_ack = ack;
    i_zero    = zero;
    @(negedge i_clk);
    check_now();
    @(posedge i_clk);
    #1;
    i_mem_ack = 1'b0;
    i_zero    = 1'b0;
    i_start   = 1'b0;
    i_halt    = 1'b0;
`ifdef DEBUG_STEP_EN
    i_step    = 1'b0;
`endif
  endtask

  task automatic fetch_decode(input int waits, input logic [5:0] op, input logic [5:0] fn);
    i_opcode = op;
    i_funct  = fn;
    for (int k = 0; k < waits; k++) begin
      push("fetch_wait", 1, 'b1000, 0, 0, 0, 0, 0, 0, 0);
      step(1'b0, 1'b0);
    end
    push("fetch_ack", 1, 'b1011, 0, 0, 0, 0, 0, 0, 0);
    step(1'b1, 1'b0);
    push("decode", 2, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1'b0, 1'b0);
  endtask

  initial begin
    i_rst_n = 1'b0; i_start = 1'b0; i_halt = 1'b0; i_zero = 1'b0; i_mem_ack = 1'b0;
    i_opcode = 6'd0; i_funct = 6'd0;
`ifdef DEBUG_STEP_EN
    i_step = 1'b0;
`endif
    #1;
    push("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1'b0, 1'b0);
    i_rst_n = 1'b1;
    push("idle_ack_ignored", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1'b1, 1'b0);

`ifdef DEBUG_STEP_EN
    for (int n = 0; n < 3; n++) begin
      i_step = 1'b1;
      push("step_pulse", (n == 0) ? 0 : 6, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1'b0, 1'b0);
      fetch_decode(0, 6'b000000, 6'b100001);
      push("addu_exec", 3, 0, 0, 0, 0, 0, 0, 'b0100, 0);
      step(1'b0, 1'b0);
      push("addu_wb", 5, 0, 0, 1, 0, 'b01, 0, 0, 1);
      step(1'b0, 1'b0);
    end
    push("halt_after_three", 6, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1'b0, 1'b0);
`else
    i_start = 1'b1;
    push("idle_start", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1'b0, 1'b0);

    fetch_decode(0, 6'b000000, 6'b100001);                       // ADDU
    push("addu_exec", 3, 0, 0, 0, 0, 0, 0, 'b0100, 0);     step(1'b0, 1'b0);
    push("addu_wb", 5, 0, 0, 1, 0, 'b01, 0, 0, 1);          step(1'b0, 1'b0);

    fetch_decode(0, 6'b100011, 6'd0);                            // LW, ack after 3 waits
    push("lw_exec", 3, 0, 0, 0, 0, 0, 1, 'b0100, 0);       step(1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      push("lw_mem_wait", 4, 'b1000, 0, 0, 0, 0, 0, 0, 0); step(1'b0, 1'b0);
    end
    push("lw_mem_ack", 4, 'b1000, 0, 0, 0, 0, 0, 0, 0);     step(1'b1, 1'b0);
    push("lw_wb", 5, 0, 0, 1, 'b01, 0, 0, 0, 1);            step(1'b0, 1'b0);

    fetch_decode(2, 6'b101011, 6'd0);                            // SW, fetch waits 2
    push("sw_exec", 3, 0, 0, 0, 0, 0, 1, 'b0100, 0);       step(1'b0, 1'b0);
    push("sw_mem_ack", 4, 'b0100, 0, 0, 0, 0, 0, 0, 1);     step(1'b1, 1'b0);

    fetch_decode(0, 6'b000100, 6'd0);                            // BEQ zero=1: taken
    push("beq_taken", 3, 'b0001, 'b01, 0, 0, 0, 0, 'b1011, 1); step(1'b0, 1'b1);
    fetch_decode(0, 6'b000101, 6'd0);                            // BNE zero=1: not taken
    push("bne_not_taken", 3, 0, 'b01, 0, 0, 0, 0, 'b1011, 1); step(1'b0, 1'b1);
    fetch_decode(0, 6'b000101, 6'd0);                            // BNE zero=0: taken
    push("bne_taken", 3, 'b0001, 'b01, 0, 0, 0, 0, 'b1011, 1); step(1'b0, 1'b0);

    fetch_decode(0, 6'b001101, 6'd0);                            // ORI
    push("ori_exec", 3, 0, 0, 0, 0, 0, 1, 'b0111, 0);      step(1'b0, 1'b0);
    push("ori_wb", 5, 0, 0, 1, 0, 0, 0, 0, 1);              step(1'b0, 1'b0);

    fetch_decode(0, 6'b000000, 6'b000000);                       // SLL (constant shift)
    push("sll_exec", 3, 0, 0, 0, 0, 0, 1, 'b0001, 0);      step(1'b0, 1'b0);
    push("sll_wb", 5, 0, 0, 1, 0, 'b01, 0, 0, 1);           step(1'b0, 1'b0);

    fetch_decode(0, 6'b000010, 6'd0);                            // J
    push("j_exec", 3, 'b0001, 'b10, 0, 0, 0, 0, 0, 1);      step(1'b0, 1'b0);

    fetch_decode(0, 6'b000000, 6'b001000);                       // JR
    push("jr_exec", 3, 'b0001, 'b11, 0, 0, 0, 0, 0, 1);     step(1'b0, 1'b0);

    fetch_decode(0, 6'b000000, 6'b001001);                       // JALR
    push("jalr_exec", 3, 'b0001, 'b11, 0, 0, 0, 0, 0, 0);   step(1'b0, 1'b0);
    push("jalr_wb", 5, 0, 0, 1, 'b10, 'b01, 0, 0, 1);       step(1'b0, 1'b0);

    fetch_decode(0, 6'b111111, 6'd0);                            // unknown opcode -> NOP
    push("unknown_exec", 3, 0, 0, 0, 0, 0, 0, 0, 1);        step(1'b0, 1'b0);

    fetch_decode(0, 6'b000011, 6'd0);                            // JAL, halt on retire
    push("jal_exec", 3, 'b0001, 'b10, 0, 0, 0, 0, 0, 0);    step(1'b0, 1'b0);
    i_halt = 1'b1;
    push("jal_wb_halt", 5, 0, 0, 1, 'b10, 'b11, 0, 0, 1);   step(1'b0, 1'b0);
    push("halt_idle", 6, 0, 0, 0, 0, 0, 0, 0, 0);           step(1'b0, 1'b0);
    i_start = 1'b1;
    push("halt_start", 6, 0, 0, 0, 0, 0, 0, 0, 0);          step(1'b0, 1'b0);

    fetch_decode(14, 6'b111111, 6'd0);                           // ack on 15th cycle wins
    push("unknown_exec2", 3, 0, 0, 0, 0, 0, 0, 0, 1);       step(1'b0, 1'b0);

    for (int k = 0; k < 15; k++) begin                           // 15 unacked cycles
      push("fetch_starve", 1, 'b1000, 0, 0, 0, 0, 0, 0, 0);  step(1'b0, 1'b0);
    end
    i_start = 1'b1;
    push("error_sticky", 7, 0, 0, 0, 0, 0, 0, 0, 0);        step(1'b1, 1'b0);
    push("error_hold", 7, 0, 0, 0, 0, 0, 0, 0, 0);          step(1'b0, 1'b0);

    i_rst_n = 1'b0;
    exp_cnt = 0;
    push("error_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);         step(1'b0, 1'b0);
    i_rst_n = 1'b1;
    i_start = 1'b1;
    push("restart", 0, 0, 0, 0, 0, 0, 0, 0, 0);             step(1'b0, 1'b0);

    // Reset asserted mid-cycle during a fetch must drop the read request without a clock edge
    push("fetch_before_reset", 1, 'b1000, 0, 0, 0, 0, 0, 0, 0);
    i_mem_ack = 1'b0;
    @(negedge i_clk);
    check_now();
    #2 i_rst_n = 1'b0;
    push("async_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 check_now();
    @(posedge i_clk);
    #1;
    push("reset_late_ack", 0, 0, 0, 0, 0, 0, 0, 0, 0);      step(1'b1, 1'b0);
    i_rst_n = 1'b1;
    push("idle_late_ack", 0, 0, 0, 0, 0, 0, 0, 0, 0);       step(1'b1, 1'b0);
`endif

    vectors++;
    assert (exp_q.size() == 0) else begin
      miscompares++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
